// File: rtl/assoc_store_pkg.sv
// assoc_pkg: shared types and default widths for the associative store.
//   op_e    : request opcode (READ/WRITE/DELETE/CLEAR)
//   state_e : control FSM states (IDLE, CLEAR sweep)
package assoc_pkg;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_KEY_W  = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_DELETE = 2'd2,
        OP_CLEAR  = 2'd3
    } op_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_e;
endpackage

// File: rtl/assoc_match.sv
// assoc_match: combinational key search over all entries.
//   valid_i/keys_i : per-entry valid bits and keys
//   key_i          : search key
//   hit_o/hit_idx_o       : key present and its (lowest) entry index
//   free_found_o/free_idx_o : a free entry exists and the lowest free index
module assoc_match #(
    parameter int DEPTH = 8,
    parameter int KEY_W = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]            valid_i,
    input  logic [DEPTH-1:0][KEY_W-1:0] keys_i,
    input  logic [KEY_W-1:0]            key_i,
    output logic                        hit_o,
    output logic [IDX_W-1:0]            hit_idx_o,
    output logic                        free_found_o,
    output logic [IDX_W-1:0]            free_idx_o
);
    logic [DEPTH-1:0] match;

    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        assign match[g] = valid_i[g] && (keys_i[g] == key_i);
    end

    // Scan high to low so the lowest index wins both encoders.
    always_comb begin
        hit_o        = 1'b0;
        hit_idx_o    = '0;
        free_found_o = 1'b0;
        free_idx_o   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_o     = 1'b1;
                hit_idx_o = IDX_W'(i);
            end
            if (!valid_i[i]) begin
                free_found_o = 1'b1;
                free_idx_o   = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/assoc_store.sv
// assoc_store: fully associative key/value store with valid/ready requests
// and a registered one-cycle response pulse.
//   clk, rst (sync, active-high)
//   req_valid/req_ready/req_op/req_key/req_data : request port
//   rsp_valid/rsp_hit/rsp_err/rsp_data          : response (cycle after accept)
//   count/full/empty                            : occupancy status
// Optional: define ASSOC_STORE_EVICT_EN to replace entries round-robin on a
// write miss while full instead of reporting an error.
module assoc_store
    import assoc_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int KEY_W  = DEF_KEY_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [KEY_W-1:0]  req_key,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    state_e                       state_q, state_d;
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][KEY_W-1:0]  keys_q, keys_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic                         rsp_hit_q, rsp_hit_d;
    logic                         rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]            rsp_data_q, rsp_data_d;
`ifdef ASSOC_STORE_EVICT_EN
    logic [IDX_W-1:0]             victim_q, victim_d;
`endif

    logic             hit, free_found;
    logic [IDX_W-1:0] hit_idx, free_idx;

    assoc_match #(.DEPTH(DEPTH), .KEY_W(KEY_W), .IDX_W(IDX_W)) u_match (
        .valid_i      (valid_q),
        .keys_i       (keys_q),
        .key_i        (req_key),
        .hit_o        (hit),
        .hit_idx_o    (hit_idx),
        .free_found_o (free_found),
        .free_idx_o   (free_idx)
    );

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        keys_d      = keys_q;
        data_d      = data_q;
        count_d     = count_q;
        idx_d       = idx_q;
        rsp_valid_d = 1'b0;
        rsp_hit_d   = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
`ifdef ASSOC_STORE_EVICT_EN
        victim_d    = victim_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    case (op_e'(req_op))
                        OP_READ: begin
                            rsp_valid_d = 1'b1;
                            rsp_hit_d   = hit;
                            if (hit) rsp_data_d = data_q[hit_idx];
                        end
                        OP_WRITE: begin
                            rsp_valid_d = 1'b1;
                            if (hit) begin
                                rsp_hit_d       = 1'b1;
                                data_d[hit_idx] = req_data;
                            end else if (free_found) begin
                                valid_d[free_idx] = 1'b1;
                                keys_d[free_idx]  = req_key;
                                data_d[free_idx]  = req_data;
                                count_d           = count_q + CNT_ONE;
                            end else begin
`ifdef ASSOC_STORE_EVICT_EN
                                // Full: replace the round-robin victim in place.
                                keys_d[victim_q] = req_key;
                                data_d[victim_q] = req_data;
                                victim_d = (victim_q == IDX_LAST) ? '0 : victim_q + IDX_ONE;
`else
                                rsp_err_d = 1'b1;
`endif
                            end
                        end
                        OP_DELETE: begin
                            rsp_valid_d = 1'b1;
                            if (hit) begin
                                rsp_hit_d        = 1'b1;
                                valid_d[hit_idx] = 1'b0;
                                count_d          = count_q - CNT_ONE;
                            end
                        end
                        OP_CLEAR: begin
                            state_d = S_CLEAR;
                            idx_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            S_CLEAR: begin
                // One entry per cycle; response goes out with the last one.
                valid_d[idx_q] = 1'b0;
                if (valid_q[idx_q]) count_d = count_q - CNT_ONE;
                if (idx_q == IDX_LAST) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            keys_q      <= '0;
            data_q      <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
`ifdef ASSOC_STORE_EVICT_EN
            victim_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            keys_q      <= keys_d;
            data_q      <= data_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
`ifdef ASSOC_STORE_EVICT_EN
            victim_q    <= victim_d;
`endif
        end
    end
endmodule

// File: tb/tb_assoc_store.sv
// tb_assoc_store: directed, table-driven checks of assoc_store (DEPTH=4),
// plus hand-written CLEAR and reset-during-CLEAR sequences.
module tb_assoc_store;
    localparam int DEPTH  = 4;
    localparam int KEY_W  = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [1:0] RD = 2'd0, WR = 2'd1, DL = 2'd2, CL = 2'd3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_op = RD;
    logic [KEY_W-1:0]  req_key = '0;
    logic [DATA_W-1:0] req_data = '0;
    logic              rsp_valid, rsp_hit, rsp_err;
    logic [DATA_W-1:0] rsp_data;
    logic [CNT_W-1:0]  count;
    logic              full, empty;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    assoc_store #(.DEPTH(DEPTH), .KEY_W(KEY_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_key(req_key), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
        .rsp_data(rsp_data), .count(count), .full(full), .empty(empty)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] key;
        logic [31:0] data;
        logic        hit;
        logic        err;
        logic [31:0] rdata;
        int          cnt;
    } vec_t;

    function automatic vec_t mk(logic [1:0] op, logic [31:0] key, logic [31:0] data,
                                logic hit, logic err, logic [31:0] rdata, int cnt);
        vec_t v;
        v.op = op; v.key = key; v.data = data;
        v.hit = hit; v.err = err; v.rdata = rdata; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one request and return just after its acceptance edge.
    task automatic issue(logic [1:0] op, logic [31:0] key, logic [31:0] data, string nm);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " ready wait"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_key = key; req_data = data;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run_vec(vec_t v, string nm);
        issue(v.op, v.key, v.data, nm);
        chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, " hit"},       32'(rsp_hit),   32'(v.hit));
        chk({nm, " err"},       32'(rsp_err),   32'(v.err));
        chk({nm, " data"},      rsp_data,       v.rdata);
        chk({nm, " count"},     32'(count),     32'(v.cnt));
        chk({nm, " full"},      32'(full),      32'(v.cnt == DEPTH));
        chk({nm, " empty"},     32'(empty),     32'(v.cnt == 0));
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tv[$];

        // Main sequence; EVICT-dependent expectations are selected here.
        tv.push_back(mk(WR, 10, 100, 0, 0, 0,   1));
        tv.push_back(mk(WR, 25, 200, 0, 0, 0,   2));
        tv.push_back(mk(WR, 50, 300, 0, 0, 0,   3));
        tv.push_back(mk(RD, 10, 0,   1, 0, 100, 3));
        tv.push_back(mk(RD, 25, 0,   1, 0, 200, 3));
        tv.push_back(mk(RD, 50, 0,   1, 0, 300, 3));
        tv.push_back(mk(RD, 99, 0,   0, 0, 0,   3));
        tv.push_back(mk(WR, 25, 555, 1, 0, 0,   3));
        tv.push_back(mk(RD, 25, 0,   1, 0, 555, 3));
        tv.push_back(mk(WR, 77, 400, 0, 0, 0,   4));
`ifdef ASSOC_STORE_EVICT_EN
        tv.push_back(mk(WR, 88, 500, 0, 0, 0,   4));   // evicts entry 0 (key 10)
        tv.push_back(mk(RD, 88, 0,   1, 0, 500, 4));
        tv.push_back(mk(RD, 10, 0,   0, 0, 0,   4));
        tv.push_back(mk(DL, 25, 0,   1, 0, 0,   3));
        tv.push_back(mk(DL, 25, 0,   0, 0, 0,   3));
        tv.push_back(mk(WR, 88, 500, 1, 0, 0,   3));   // already resident
        tv.push_back(mk(RD, 88, 0,   1, 0, 500, 3));
`else
        tv.push_back(mk(WR, 88, 500, 0, 1, 0,   4));   // full, refused
        tv.push_back(mk(RD, 88, 0,   0, 0, 0,   4));
        tv.push_back(mk(RD, 10, 0,   1, 0, 100, 4));
        tv.push_back(mk(DL, 25, 0,   1, 0, 0,   3));
        tv.push_back(mk(DL, 25, 0,   0, 0, 0,   3));
        tv.push_back(mk(WR, 88, 500, 0, 0, 0,   4));   // fills freed entry 1
        tv.push_back(mk(RD, 88, 0,   1, 0, 500, 4));
`endif

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post-rst ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("post-rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post-rst count",     32'(count),     32'd0);
        chk("post-rst empty",     32'(empty),     32'd1);
        chk("post-rst full",      32'(full),      32'd0);
        chk("post-rst rsp_data",  rsp_data,       32'd0);

        foreach (tv[i]) run_vec(tv[i], $sformatf("v%0d", i));

        // Response is a single pulse once requests stop.
        @(posedge clk);
        #1;
        chk("pulse drop", 32'(rsp_valid), 32'd0);

        // CLEAR sweep: ready low for DEPTH cycles, response on the last edge.
        issue(CL, 0, 0, "clr");
        chk("clr ready c0", 32'(req_ready), 32'd0);
        chk("clr rsp c0",   32'(rsp_valid), 32'd0);
        for (int k = 1; k < DEPTH; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("clr ready c%0d", k), 32'(req_ready), 32'd0);
            chk($sformatf("clr rsp c%0d", k),   32'(rsp_valid), 32'd0);
            if (k == 2) chk("clr count mid", 32'(count), 32'd2);
        end
        @(posedge clk);
        #1;
        chk("clr done rsp_valid", 32'(rsp_valid), 32'd1);
        chk("clr done hit",       32'(rsp_hit),   32'd0);
        chk("clr done err",       32'(rsp_err),   32'd0);
        chk("clr done ready",     32'(req_ready), 32'd1);
        chk("clr done count",     32'(count),     32'd0);
        chk("clr done empty",     32'(empty),     32'd1);
        @(posedge clk);
        #1;
        chk("clr pulse drop", 32'(rsp_valid), 32'd0);
        run_vec(mk(RD, 50, 0, 0, 0, 0, 0), "post-clr rd50");

        // Reset in the second cycle of a CLEAR aborts it.
        run_vec(mk(WR, 10, 100, 0, 0, 0, 1), "ra wr10");
        run_vec(mk(WR, 25, 200, 0, 0, 0, 2), "ra wr25");
        issue(CL, 0, 0, "ra clr");
        @(posedge clk);
        #1;
        chk("ra count after e1", 32'(count), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ra ready in rst", 32'(req_ready), 32'd0);
        chk("ra count in rst", 32'(count),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ra ready",     32'(req_ready), 32'd1);
        chk("ra rsp_valid", 32'(rsp_valid), 32'd0);
        chk("ra count",     32'(count),     32'd0);
        run_vec(mk(RD, 10, 0,  0, 0, 0,  0), "ra rd10");
        run_vec(mk(RD, 25, 0,  0, 0, 0,  0), "ra rd25");
        run_vec(mk(WR, 5,  55, 0, 0, 0,  1), "ra wr5");
        run_vec(mk(RD, 5,  0,  1, 0, 55, 1), "ra rd5");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
